// File: rtl/dac_pkg.sv
// Shared types and beat geometry for the DAC waveform playback path.
package dac_pkg;
    localparam int SAMPLE_BITS      = 16;
    localparam int SAMPLES_PER_BEAT = 8;
    localparam int DATA_WIDTH       = SAMPLE_BITS * SAMPLES_PER_BEAT;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        PLAY,
        DRAIN
    } state_t;
endpackage

// File: rtl/dac_wave_ram.sv
// Simple dual-port waveform RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module dac_wave_ram
    import dac_pkg::*;
#(
    parameter int DATA_WIDTH = dac_pkg::DATA_WIDTH,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/dac_playback_stream.sv
// Streams a RAM-resident waveform to the RF DAC as an AXI4-Stream master,
// in one-shot or loop mode, optionally gated by an external trigger.
module dac_playback_stream
    import dac_pkg::*;
#(
    parameter int DATA_WIDTH = dac_pkg::DATA_WIDTH,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_BITS-1:0]  cfg_len,
    input  logic                  cfg_loop,
    input  logic                  cfg_trig_en,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  trig,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  done
);
    state_t                state;
    state_t                state_next;
    logic                  done_next;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic [ADDR_BITS-1:0]  len_q;
    logic                  loop_q;
    logic                  rd_en;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    logic [1:0]            count;
    logic [1:0]            count_next;
    logic [2:0]            occ;
    logic                  pop;
    logic                  push;
    logic                  flush;
    logic                  drain_flush;
    logic                  last_read;

    dac_wave_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    assign m_axis_tvalid = (count != 2'd0);
    assign m_axis_tdata  = slot0;
    assign busy          = (state != IDLE);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign last_read     = (rd_ptr == len_q);
    assign flush         = (state == PLAY) && stop;
    // A stopped playback drops everything not yet presented, including reads in flight.
    assign push          = rd_valid && !flush && !((state == DRAIN) && drain_flush);
    // Occupancy the buffer will see if a read is issued now, counting the read in flight.
    assign occ           = {1'b0, count} + {2'b00, rd_valid} - {2'b00, pop};

    always_comb begin
        count_next = count + {1'b0, push} - {1'b0, pop};
        if (flush) begin
            count_next = (count != 2'd0 && !pop) ? 2'd1 : 2'd0;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = cfg_trig_en ? ARMED : PLAY;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (trig) begin
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_next = DRAIN;
                end else if (occ <= 3'd1) begin
                    rd_en = 1'b1;
                    if (last_read && !loop_q) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (count_next == 2'd0 && (drain_flush || !rd_valid)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            rd_ptr      <= '0;
            rd_valid    <= 1'b0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            drain_flush <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (state == IDLE && start) begin
                rd_ptr      <= '0;
                len_q       <= cfg_len;
                loop_q      <= cfg_loop;
                drain_flush <= 1'b0;
            end else if (rd_en) begin
                rd_ptr <= last_read ? '0 : rd_ptr + 1'b1;
            end
            if (flush) begin
                drain_flush <= 1'b1;
            end
        end
    end

    // Two-entry skid buffer; slot0 is the beat on the bus.
    always_ff @(posedge aclk) begin
        if (arst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            count <= count_next;
            if (!flush) begin
                if (pop) begin
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                        if (push) begin
                            slot1 <= ram_q;
                        end
                    end else if (push) begin
                        slot0 <= ram_q;
                    end
                end else if (push) begin
                    if (count == 2'd0) begin
                        slot0 <= ram_q;
                    end else begin
                        slot1 <= ram_q;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dac_playback_stream.sv
// Randomized self-checking bench for dac_playback_stream against a shadow-RAM
// model of the expected beat sequence and the stream handshake rules.
module tb_dac_playback_stream;
    import dac_pkg::*;

    localparam int DW = 128;
    localparam int AB = 10;

    logic          aclk = 1'b0;
    logic          arst;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AB-1:0] cfg_len;
    logic          cfg_loop;
    logic          cfg_trig_en;
    logic          start;
    logic          stop;
    logic          trig;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          busy;
    logic          done;

    always #5 aclk = ~aclk;

    dac_playback_stream #(
        .DATA_WIDTH (DW),
        .ADDR_BITS  (AB)
    ) dut (
        .aclk          (aclk),
        .arst          (arst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .cfg_len       (cfg_len),
        .cfg_loop      (cfg_loop),
        .cfg_trig_en   (cfg_trig_en),
        .start         (start),
        .stop          (stop),
        .trig          (trig),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done)
    );

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    logic [DW-1:0] shadow [0:(1<<AB)-1];
    logic [DW-1:0] got_q [$];
    int            got_cyc [$];
    logic [DW-1:0] exp_q [$];
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic          prev_arst = 1'b1;
    logic [DW-1:0] prev_data = '0;

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Handshake rules and accepted-beat capture, sampled mid-cycle.
    always @(negedge aclk) begin
        if (!prev_arst && prev_valid && !prev_ready) begin
            checkOutput("hold_valid", DW'(m_axis_tvalid), DW'(1));
            checkOutput("hold_data", m_axis_tdata, prev_data);
        end
        if (m_axis_tvalid && m_axis_tready && !arst) begin
            got_q.push_back(m_axis_tdata);
            got_cyc.push_back(cyc);
        end
        if (done && !arst) done_cnt++;
        prev_valid = m_axis_tvalid;
        prev_ready = m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_arst  = arst;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic t);
        start = s;
        stop  = p;
        trig  = t;
        step();
        start = 1'b0;
        stop  = 1'b0;
        trig  = 1'b0;
    endtask

    task automatic loadBeat(input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a[AB-1:0];
        wr_data = d;
        step();
        wr_en     = 1'b0;
        shadow[a] = d;
    endtask

    task automatic clearRun();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic waitIdle(input int limit, input logic rnd);
        int n = 0;
        while (busy && n < limit) begin
            if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        checkOutput("idle_timeout", DW'(busy), '0);
        m_axis_tready = 1'b1;
        step();
    endtask

    // Compares captured beats with the expected list; first_cyc >= 0 also demands no bubbles.
    task automatic checkSeq(input string tag, input int first_cyc);
        checkOutput({tag, "_count"}, DW'(got_q.size()), DW'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checkOutput(tag, got_q[i], exp_q[i]);
            if (first_cyc >= 0) checkOutput({tag, "_cyc"}, DW'(got_cyc[i]), DW'(first_cyc + i));
        end
    endtask

    function automatic logic [DW-1:0] randBeat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int            s;
        int            t;
        int            w;
        int            n;
        logic [15:0]   a16;
        logic [DW-1:0] old2;

        arst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cfg_len = '0; cfg_loop = 1'b0; cfg_trig_en = 1'b0;
        start = 1'b0; stop = 1'b0; trig = 1'b0; m_axis_tready = 1'b1;
        step(3);
        checkOutput("rst_tvalid", DW'(m_axis_tvalid), '0);
        checkOutput("rst_tdata", m_axis_tdata, '0);
        checkOutput("rst_busy", DW'(busy), '0);
        checkOutput("rst_done", DW'(done), '0);
        arst = 1'b0;
        step();

        $display("[TB] one-shot, len 3, full rate");
        for (int i = 0; i < 4; i++) begin
            a16 = i[15:0];
            loadBeat(i, {8{a16}});
        end
        clearRun();
        cfg_len = 10'd3; cfg_loop = 1'b0; cfg_trig_en = 1'b0;
        s = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("a_busy", DW'(busy), DW'(1));
        step();
        checkOutput("a_lat", DW'(m_axis_tvalid), '0);
        step();
        for (int k = 0; k < 4; k++) begin
            checkOutput("a_valid", DW'(m_axis_tvalid), DW'(1));
            checkOutput("a_data", m_axis_tdata, shadow[k]);
            step();
        end
        checkOutput("a_end_valid", DW'(m_axis_tvalid), '0);
        checkOutput("a_done", DW'(done), DW'(1));
        checkOutput("a_end_busy", DW'(busy), '0);
        step();
        checkOutput("a_done_once", DW'(done), '0);
        for (int k = 0; k < 4; k++) exp_q.push_back(shadow[k]);
        checkSeq("a_seq", s + 3);

        $display("[TB] loop, len 3, stop after 20 cycles");
        clearRun();
        cfg_loop = 1'b1;
        s = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(19);
        t = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("b_stop_valid", DW'(m_axis_tvalid), '0);
        waitIdle(20, 1'b0);
        checkOutput("b_done_cnt", DW'(done_cnt), DW'(1));
        for (int k = 0; k <= t - (s + 3); k++) exp_q.push_back(shadow[k % 4]);
        checkSeq("b_seq", s + 3);

        $display("[TB] one-shot, len 7, random backpressure");
        for (int i = 0; i < 8; i++) loadBeat(i, randBeat());
        clearRun();
        cfg_len = 10'd7; cfg_loop = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitIdle(400, 1'b1);
        checkOutput("c_done_cnt", DW'(done_cnt), DW'(1));
        for (int k = 0; k < 8; k++) exp_q.push_back(shadow[k]);
        checkSeq("c_seq", -1);

        $display("[TB] triggered start");
        clearRun();
        cfg_len = 10'd3; cfg_trig_en = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 37; i++) begin
            checkOutput("d_armed_busy", DW'(busy), DW'(1));
            checkOutput("d_armed_valid", DW'(m_axis_tvalid), '0);
            trig = (i == 35);
            step();
            trig = 1'b0;
        end
        checkOutput("d_first_valid", DW'(m_axis_tvalid), DW'(1));
        checkOutput("d_first_data", m_axis_tdata, shadow[0]);
        waitIdle(40, 1'b1);
        checkOutput("d_done_cnt", DW'(done_cnt), DW'(1));
        for (int k = 0; k < 4; k++) exp_q.push_back(shadow[k]);
        checkSeq("d_seq", -1);

        clearRun();
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(14);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("d_stop_busy", DW'(busy), '0);
        step(5);
        checkOutput("d_stop_valid", DW'(m_axis_tvalid), '0);
        checkOutput("d_stop_nodone", DW'(done_cnt), '0);
        checkOutput("d_stop_beats", DW'(got_q.size()), '0);

        $display("[TB] single-beat loop, reset, replay");
        a16 = 16'h1234;
        loadBeat(0, {8{a16}});
        clearRun();
        cfg_len = 10'd0; cfg_loop = 1'b1; cfg_trig_en = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            step();
        end
        m_axis_tready = 1'b1;
        step(2);
        for (int i = 0; i < 10; i++) begin
            checkOutput("e_stream_valid", DW'(m_axis_tvalid), DW'(1));
            step();
        end
        checkOutput("e_some_beats", DW'(got_q.size() >= 12), DW'(1));
        for (int k = 0; k < got_q.size(); k++) checkOutput("e_beat", got_q[k], {8{a16}});
        arst = 1'b1;
        step();
        arst = 1'b0;
        checkOutput("e_rst_valid", DW'(m_axis_tvalid), '0);
        checkOutput("e_rst_busy", DW'(busy), '0);
        checkOutput("e_rst_tdata", m_axis_tdata, '0);
        step();
        clearRun();
        cfg_len = 10'd3; cfg_loop = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitIdle(40, 1'b1);
        for (int k = 0; k < 4; k++) exp_q.push_back(shadow[k]);
        checkSeq("e_replay", -1);

        $display("[TB] rewrite during loop, start while busy");
        clearRun();
        cfg_len = 10'd3; cfg_loop = 1'b1;
        s = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0);
        step(7);
        w = cyc;
        old2 = shadow[2];
        shadow[2] = randBeat();
        wr_en = 1'b1; wr_addr = 10'd2; wr_data = shadow[2];
        start = 1'b1; cfg_len = 10'd0;
        step();
        wr_en = 1'b0; start = 1'b0; cfg_len = 10'd3;
        step(21);
        t = cyc;
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitIdle(20, 1'b0);
        checkOutput("f_done_cnt", DW'(done_cnt), DW'(1));
        n = t - (s + 3) + 1;
        for (int k = 0; k < n; k++) begin
            if ((k % 4) == 2 && (s + 1 + k) <= w) exp_q.push_back(old2);
            else exp_q.push_back(shadow[k % 4]);
        end
        checkSeq("f_seq", s + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
